// File: rtl/mc_controller.sv
// Multicycle main control FSM for the 16-bit datapath; drives strobes, mux selects and aluop.
// Optional feature: define CTRL_ILLEGAL_TRAP_EN to latch illegal opcodes into a TRAP state.
module mc_controller #(
  parameter int OPW    = 4,
  parameter int ALUOPW = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [OPW-1:0]    opcode,
  input  logic              zero,
  input  logic              mem_ready,
  output logic              pc_en,
  output logic              ir_write,
  output logic              iord,
  output logic              mem_write,
  output logic              reg_write,
  output logic              reg_dst,
  output logic              mem_to_reg,
  output logic              alusrca,
  output logic [1:0]        alusrcb,
  output logic [ALUOPW-1:0] aluop,
  output logic [1:0]        pcsrc,
  output logic [3:0]        state_o,
  output logic              trap
);

  localparam logic [3:0] ST_FETCH  = 4'd0;
  localparam logic [3:0] ST_DECODE = 4'd1;
  localparam logic [3:0] ST_MEMADR = 4'd2;
  localparam logic [3:0] ST_MEMRD  = 4'd3;
  localparam logic [3:0] ST_MEMWB  = 4'd4;
  localparam logic [3:0] ST_MEMWR  = 4'd5;
  localparam logic [3:0] ST_EXEC   = 4'd6;
  localparam logic [3:0] ST_ALUWB  = 4'd7;
  localparam logic [3:0] ST_ADDIEX = 4'd8;
  localparam logic [3:0] ST_ADDIWB = 4'd9;
  localparam logic [3:0] ST_BRANCH = 4'd10;
  localparam logic [3:0] ST_JUMP   = 4'd11;
  localparam logic [3:0] ST_TRAP   = 4'd12;

  localparam logic [OPW-1:0] OP_R    = OPW'(0);
  localparam logic [OPW-1:0] OP_ADDI = OPW'(1);
  localparam logic [OPW-1:0] OP_LW   = OPW'(2);
  localparam logic [OPW-1:0] OP_SW   = OPW'(3);
  localparam logic [OPW-1:0] OP_BEQ  = OPW'(4);
  localparam logic [OPW-1:0] OP_J    = OPW'(5);

  localparam logic [ALUOPW-1:0] ALU_ADD   = ALUOPW'(0);
  localparam logic [ALUOPW-1:0] ALU_SUB   = ALUOPW'(1);
  localparam logic [ALUOPW-1:0] ALU_FUNCT = ALUOPW'(2);

  logic [3:0] state_q, state_d;
  logic [3:0] illegal_next;

  // Strobes before reset gating; reset must silence them in the same cycle.
  logic pc_en_m, ir_write_m, mem_write_m, reg_write_m;

`ifdef CTRL_ILLEGAL_TRAP_EN
  assign illegal_next = ST_TRAP;
`else
  assign illegal_next = ST_FETCH;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = ST_FETCH;
    case (state_q)
      ST_FETCH:  state_d = mem_ready ? ST_DECODE : ST_FETCH;
      ST_DECODE: begin
        case (opcode)
          OP_R:         state_d = ST_EXEC;
          OP_ADDI:      state_d = ST_ADDIEX;
          OP_LW, OP_SW: state_d = ST_MEMADR;
          OP_BEQ:       state_d = ST_BRANCH;
          OP_J:         state_d = ST_JUMP;
          default:      state_d = illegal_next;
        endcase
      end
      ST_MEMADR: state_d = (opcode == OP_SW) ? ST_MEMWR : ST_MEMRD;
      ST_MEMRD:  state_d = mem_ready ? ST_MEMWB : ST_MEMRD;
      ST_MEMWB:  state_d = ST_FETCH;
      ST_MEMWR:  state_d = mem_ready ? ST_FETCH : ST_MEMWR;
      ST_EXEC:   state_d = ST_ALUWB;
      ST_ALUWB:  state_d = ST_FETCH;
      ST_ADDIEX: state_d = ST_ADDIWB;
      ST_ADDIWB: state_d = ST_FETCH;
      ST_BRANCH: state_d = ST_FETCH;
      ST_JUMP:   state_d = ST_FETCH;
      // Without the trap feature this encoding is unreachable and behaves like 13-15.
      ST_TRAP:   state_d = illegal_next;
      default:   state_d = ST_FETCH;
    endcase
  end

  always_comb begin
    pc_en_m     = 1'b0;
    ir_write_m  = 1'b0;
    mem_write_m = 1'b0;
    reg_write_m = 1'b0;
    iord        = 1'b0;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    alusrca     = 1'b0;
    alusrcb     = 2'b00;
    aluop       = ALU_ADD;
    pcsrc       = 2'b00;
    case (state_q)
      ST_FETCH: begin
        alusrcb    = 2'b01;
        pc_en_m    = mem_ready;
        ir_write_m = mem_ready;
      end
      ST_DECODE: alusrcb = 2'b11;
      ST_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      ST_MEMRD: iord = 1'b1;
      ST_MEMWB: begin
        reg_write_m = 1'b1;
        mem_to_reg  = 1'b1;
      end
      ST_MEMWR: begin
        iord        = 1'b1;
        mem_write_m = 1'b1;
      end
      ST_EXEC: begin
        alusrca = 1'b1;
        aluop   = ALU_FUNCT;
      end
      ST_ALUWB: begin
        reg_write_m = 1'b1;
        reg_dst     = 1'b1;
      end
      ST_ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      ST_ADDIWB: reg_write_m = 1'b1;
      ST_BRANCH: begin
        alusrca = 1'b1;
        aluop   = ALU_SUB;
        pcsrc   = 2'b01;
        pc_en_m = zero;
      end
      ST_JUMP: begin
        pcsrc   = 2'b10;
        pc_en_m = 1'b1;
      end
`ifdef CTRL_ILLEGAL_TRAP_EN
      ST_TRAP: ;
`endif
      default: begin
        alusrcb    = 2'b01;
        pc_en_m    = mem_ready;
        ir_write_m = mem_ready;
      end
    endcase
  end

  assign pc_en     = pc_en_m     & ~reset;
  assign ir_write  = ir_write_m  & ~reset;
  assign mem_write = mem_write_m & ~reset;
  assign reg_write = reg_write_m & ~reset;
  assign state_o   = state_q;

`ifdef CTRL_ILLEGAL_TRAP_EN
  assign trap = (state_q == ST_TRAP) & ~reset;
`else
  assign trap = 1'b0;
`endif

endmodule
